// File: rtl/mem_port_arbiter.sv
// Arbiter between the instruction-fetch port and the load/store port for one
// single-port memory. The memory has a 1-cycle registered read and byte-lane
// write masks. The arbiter generates store lane masks and replicated write
// data, and it aligns and extends load data on the cycle after the grant.
module mem_port_arbiter #(
    parameter int unsigned DATA_PRIO = 1,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_err,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    // load/store port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_err,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // memory side
    output logic        m_we,
    output logic [31:0] m_a,
    output logic [31:0] m_wd,
    output logic [3:0]  m_wm,
    input  logic [31:0] m_rd
);

    localparam int unsigned       WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [1:0]        SZ_BYTE  = 2'b00;
    localparam logic [1:0]        SZ_HALF  = 2'b01;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    port_e             rr_last;
    logic [WAIT_W-1:0] wait_cnt;
    logic              pend_i;
    logic              pend_d;
    logic [1:0]        pend_off;
    logic [1:0]        pend_size;
    logic              pend_uns;

    logic              pick_d;
    logic              gnt_i;
    logic              gnt_d;
    logic              i_bad;
    logic              d_bad;
    logic              d_store;
    logic              d_load;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Alignment and size legality of each port's request
    always_comb begin
        i_bad = |i_addr[1:0];
        d_bad = 1'b1;
        case (d_size)
            SZ_BYTE: d_bad = 1'b0;
            SZ_HALF: d_bad = d_addr[0];
            2'b10:   d_bad = |d_addr[1:0];
            default: d_bad = 1'b1;
        endcase
    end

    // Pick one winner per cycle; a lone requester always wins
    always_comb begin
        pick_d = d_req;
        if (d_req && i_req) begin
            if (DATA_PRIO != 0) begin
                pick_d = (wait_cnt != WAIT_MAX);
            end else begin
                pick_d = (rr_last == PORT_I);
            end
        end
        gnt_d = d_req && pick_d;
        gnt_i = i_req && !gnt_d;
    end

    // Grant, error and memory-request signals for the winning port
    always_comb begin
        i_gnt   = gnt_i;
        d_gnt   = gnt_d;
        i_err   = gnt_i && i_bad;
        d_err   = gnt_d && d_bad;
        d_store = gnt_d && d_we && !d_bad;
        d_load  = gnt_d && !d_we && !d_bad;
        m_a     = '0;
        m_we    = d_store;
        m_wm    = '0;
        m_wd    = '0;
        if (gnt_d) begin
            m_a = d_addr;
        end else if (gnt_i) begin
            m_a = i_addr;
        end
        if (d_store) begin
            case (d_size)
                SZ_BYTE: begin
                    m_wm = 4'(4'b0001 << d_addr[1:0]);
                    m_wd = {4{d_wdata[7:0]}};
                end
                SZ_HALF: begin
                    m_wm = 4'(4'b0011 << d_addr[1:0]);
                    m_wd = {2{d_wdata[15:0]}};
                end
                default: begin
                    m_wm = 4'b1111;
                    m_wd = d_wdata;
                end
            endcase
        end
    end

    // Pending-read tracking, round-robin history and fetch starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_i    <= 1'b0;
            pend_d    <= 1'b0;
            pend_off  <= 2'b00;
            pend_size <= 2'b00;
            pend_uns  <= 1'b0;
            rr_last   <= PORT_D;
            wait_cnt  <= '0;
        end else begin
            pend_i <= gnt_i && !i_bad;
            pend_d <= d_load;
            if (d_load) begin
                pend_off  <= d_addr[1:0];
                pend_size <= d_size;
                pend_uns  <= d_unsigned;
            end
            if (gnt_d) begin
                rr_last <= PORT_D;
            end else if (gnt_i) begin
                rr_last <= PORT_I;
            end
            if (DATA_PRIO == 0 || !i_req || gnt_i) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Return path: select lanes from memory data and extend; zero when not valid
    always_comb begin
        i_rvalid = pend_i && !reset;
        d_rvalid = pend_d && !reset;
        i_rdata  = i_rvalid ? m_rd : '0;
        byte_sel = m_rd[7:0];
        case (pend_off)
            2'b01:   byte_sel = m_rd[15:8];
            2'b10:   byte_sel = m_rd[23:16];
            2'b11:   byte_sel = m_rd[31:24];
            default: byte_sel = m_rd[7:0];
        endcase
        half_sel = pend_off[1] ? m_rd[31:16] : m_rd[15:0];
        d_rdata  = '0;
        if (d_rvalid) begin
            case (pend_size)
                SZ_BYTE: d_rdata = {{24{!pend_uns && byte_sel[7]}}, byte_sel};
                SZ_HALF: d_rdata = {{16{!pend_uns && half_sel[15]}}, half_sel};
                default: d_rdata = m_rd;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one fixed-priority instance backed by a byte-mask
// memory and one round-robin instance whose memory echoes the last address.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_wdata;

    logic        p_i_gnt, p_i_err, p_i_rvalid, p_d_gnt, p_d_err, p_d_rvalid, p_m_we;
    logic [31:0] p_i_rdata, p_d_rdata, p_m_a, p_m_wd, p_m_rd;
    logic [3:0]  p_m_wm;
    logic        r_i_gnt, r_i_err, r_i_rvalid, r_d_gnt, r_d_err, r_d_rvalid, r_m_we;
    logic [31:0] r_i_rdata, r_d_rdata, r_m_a, r_m_wd, r_m_rd;
    logic [3:0]  r_m_wm;

    logic [31:0] pmem [0:63];
    logic [31:0] mm   [0:63];
    logic [31:0] exp_q [$];
    int          errors;
    int          checks;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } op_t;

    mem_port_arbiter #(.DATA_PRIO(1), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(p_i_gnt), .i_err(p_i_err),
        .i_rvalid(p_i_rvalid), .i_rdata(p_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(p_d_gnt), .d_err(p_d_err),
        .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
        .m_we(p_m_we), .m_a(p_m_a), .m_wd(p_m_wd), .m_wm(p_m_wm), .m_rd(p_m_rd)
    );

    mem_port_arbiter #(.DATA_PRIO(0), .MAX_WAIT(4)) dut_rr (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(r_i_gnt), .i_err(r_i_err),
        .i_rvalid(r_i_rvalid), .i_rdata(r_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
        .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_gnt(r_d_gnt), .d_err(r_d_err),
        .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
        .m_we(r_m_we), .m_a(r_m_a), .m_wd(r_m_wd), .m_wm(r_m_wm), .m_rd(r_m_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-masked memory with registered read for the fixed-priority instance
    always @(posedge clk) begin
        if (p_m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (p_m_wm[b]) pmem[p_m_a[7:2]][8*b +: 8] <= p_m_wd[8*b +: 8];
            end
        end
        p_m_rd <= pmem[p_m_a[7:2]];
    end

    // Echo memory for the round-robin instance: read data is last cycle's address
    always @(posedge clk) r_m_rd <= r_m_a;

    function automatic logic [3:0] exp_mask(input logic [1:0] size, input logic [1:0] off);
        int n;
        logic [3:0] m;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int b = 0; b < 4; b++) m[b] = (b >= int'(off)) && (b < int'(off) + n);
        return m;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (size == 2'd1) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> (8 * int'(off));
        if (size == 2'd0) return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        if (size == 2'd1) return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        return word;
    endfunction

    function automatic logic is_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd2 && addr[1:0] != 2'b00) || (size == 2'd1 && addr[0]);
    endfunction

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_size = 2'd0; d_unsigned = 1'b0; d_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({p_i_gnt, p_i_err, p_i_rvalid, p_d_gnt, p_d_err, p_d_rvalid, p_m_we} !== 7'b0) begin
            errors++; $display("FAIL reset_p_flags got=%b want=0",
                {p_i_gnt, p_i_err, p_i_rvalid, p_d_gnt, p_d_err, p_d_rvalid, p_m_we});
        end
        checks++;
        if ({p_i_rdata, p_d_rdata, p_m_a, p_m_wd, p_m_wm} !== 132'b0) begin
            errors++; $display("FAIL reset_p_buses m_a=%h m_wd=%h m_wm=%b", p_m_a, p_m_wd, p_m_wm);
        end
        checks++;
        if ({r_i_gnt, r_d_gnt, r_i_rvalid, r_d_rvalid, r_m_we, r_m_wm} !== 9'b0 || r_m_a !== 32'h0) begin
            errors++; $display("FAIL reset_rr_outputs m_a=%h want=0", r_m_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_load_store();
        op_t ops [$];
        op_t op;
        logic exp_pend;
        logic err;
        logic [31:0] e;
        int n;
        ops.push_back('{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF}); // SW
        ops.push_back('{1'b0, 32'h13, 2'd0, 1'b0, 32'h0});        // LB -> FFFFFFDE
        ops.push_back('{1'b0, 32'h13, 2'd0, 1'b1, 32'h0});        // LBU -> DE
        ops.push_back('{1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678}); // SW
        ops.push_back('{1'b1, 32'h21, 2'd0, 1'b0, 32'h0000005A}); // SB
        ops.push_back('{1'b0, 32'h22, 2'd1, 1'b0, 32'h0});        // LH -> 1234
        ops.push_back('{1'b0, 32'h10, 2'd1, 1'b0, 32'h0});        // LH -> FFFFBEEF
        ops.push_back('{1'b1, 32'h12, 2'd1, 1'b0, 32'h0000CAFE}); // SH upper half
        ops.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 32'h0});        // LW
        ops.push_back('{1'b0, 32'h06, 2'd2, 1'b0, 32'h0});        // LW misaligned
        ops.push_back('{1'b0, 32'h21, 2'd1, 1'b0, 32'h0});        // LH misaligned
        ops.push_back('{1'b1, 32'h00, 2'd3, 1'b0, 32'hFFFFFFFF}); // illegal size store
        ops.push_back('{1'b0, 32'h12, 2'd0, 1'b0, 32'h0});        // LB, then store same byte
        ops.push_back('{1'b1, 32'h12, 2'd0, 1'b0, 32'h00000011}); // SB
        ops.push_back('{1'b0, 32'h12, 2'd0, 1'b1, 32'h0});        // LBU -> 11
        n = ops.size();
        exp_pend = 1'b0;
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            if (k < n) begin
                op = ops[k];
                d_req = 1'b1; d_we = op.we; d_addr = op.addr; d_size = op.size;
                d_unsigned = op.uns; d_wdata = op.wdata;
            end else begin
                idle_inputs();
            end
            #1;
            checks++;
            if (p_d_rvalid !== exp_pend) begin
                errors++; $display("FAIL ls_rvalid step=%0d got=%b want=%b", k, p_d_rvalid, exp_pend);
            end
            if (p_d_rvalid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ls_unexpected_rvalid step=%0d rdata=%h", k, p_d_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (p_d_rdata !== e) begin
                        errors++; $display("FAIL ls_rdata step=%0d got=%h want=%h", k, p_d_rdata, e);
                    end
                end
            end else begin
                checks++;
                if (p_d_rdata !== 32'h0) begin
                    errors++; $display("FAIL ls_rdata_idle step=%0d got=%h want=0", k, p_d_rdata);
                end
            end
            exp_pend = 1'b0;
            if (k < n) begin
                err = is_err(op.size, op.addr);
                checks++;
                if (p_d_gnt !== 1'b1 || p_i_gnt !== 1'b0 || p_d_err !== err || p_m_a !== op.addr) begin
                    errors++; $display("FAIL ls_grant step=%0d gnt=%b err=%b(want %b) m_a=%h(want %h)",
                        k, p_d_gnt, p_d_err, err, p_m_a, op.addr);
                end
                if (op.we && !err) begin
                    checks++;
                    if (p_m_we !== 1'b1 || p_m_wm !== exp_mask(op.size, op.addr[1:0]) ||
                        p_m_wd !== exp_wd(op.size, op.wdata)) begin
                        errors++; $display("FAIL ls_store step=%0d we=%b wm=%b(want %b) wd=%h(want %h)",
                            k, p_m_we, p_m_wm, exp_mask(op.size, op.addr[1:0]), p_m_wd,
                            exp_wd(op.size, op.wdata));
                    end
                    for (int b = 0; b < 4; b++) begin
                        if (exp_mask(op.size, op.addr[1:0])[b])
                            mm[op.addr[7:2]][8*b +: 8] = exp_wd(op.size, op.wdata)[8*b +: 8];
                    end
                end else begin
                    checks++;
                    if (p_m_we !== 1'b0 || p_m_wm !== 4'b0) begin
                        errors++; $display("FAIL ls_no_write step=%0d we=%b wm=%b want 0", k, p_m_we, p_m_wm);
                    end
                end
                if (!op.we && !err) begin
                    exp_q.push_back(exp_load(mm[op.addr[7:2]], op.addr[1:0], op.size, op.uns));
                    exp_pend = 1'b1;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL ls_drain left=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_priority();
        int wc;
        logic exp_i, prev_i, prev_d;
        wc = 0; prev_i = 1'b0; prev_d = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k < 10) begin
                i_req = 1'b1; i_addr = 32'h20;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2; d_unsigned = 1'b0;
            end else begin
                idle_inputs();
            end
            #1;
            checks++;
            if (p_i_rvalid !== prev_i || p_d_rvalid !== prev_d) begin
                errors++; $display("FAIL prio_rvalid cyc=%0d got i=%b d=%b want i=%b d=%b",
                    k, p_i_rvalid, p_d_rvalid, prev_i, prev_d);
            end
            if (prev_i) begin
                checks++;
                if (p_i_rdata !== mm[8]) begin
                    errors++; $display("FAIL prio_fetch_data cyc=%0d got=%h want=%h", k, p_i_rdata, mm[8]);
                end
            end
            if (k < 10) begin
                exp_i = (wc == 4);
                checks++;
                if (p_i_gnt !== exp_i || p_d_gnt !== !exp_i) begin
                    errors++; $display("FAIL prio_grant cyc=%0d got i=%b d=%b want i=%b", k, p_i_gnt, p_d_gnt, exp_i);
                end
                wc = exp_i ? 0 : ((wc < 4) ? wc + 1 : 4);
                prev_i = exp_i; prev_d = !exp_i;
            end
        end
    endtask

    task automatic test_round_robin();
        logic last_d, exp_i, prev_i, prev_d;
        @(posedge clk); #1;
        reset = 1'b1; idle_inputs();
        last_d = 1'b1; prev_i = 1'b0; prev_d = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            i_req = (k < 8); i_addr = 32'h20;
            d_req = (k < 10); d_we = 1'b0; d_addr = 32'h10; d_size = 2'd2;
            #1;
            checks++;
            if (r_i_rvalid !== prev_i || r_d_rvalid !== prev_d) begin
                errors++; $display("FAIL rr_rvalid cyc=%0d got i=%b d=%b want i=%b d=%b",
                    k, r_i_rvalid, r_d_rvalid, prev_i, prev_d);
            end
            if (prev_i || prev_d) begin
                checks++;
                if ((prev_i && r_i_rdata !== 32'h20) || (prev_d && r_d_rdata !== 32'h10)) begin
                    errors++; $display("FAIL rr_rdata cyc=%0d got i=%h d=%h", k, r_i_rdata, r_d_rdata);
                end
            end
            prev_i = 1'b0; prev_d = 1'b0;
            if (k < 10) begin
                exp_i = (k < 8) && last_d;
                checks++;
                if (r_i_gnt !== exp_i || r_d_gnt !== !exp_i) begin
                    errors++; $display("FAIL rr_grant cyc=%0d got i=%b d=%b want i=%b", k, r_i_gnt, r_d_gnt, exp_i);
                end
                last_d = !exp_i; prev_i = exp_i; prev_d = !exp_i;
            end
        end
        idle_inputs();
    endtask

    task automatic test_fetch();
        @(posedge clk); #1;
        idle_inputs(); i_req = 1'b1; i_addr = 32'h22;
        #1;
        checks++;
        if (p_i_gnt !== 1'b1 || p_i_err !== 1'b1 || p_m_we !== 1'b0 || p_m_wm !== 4'b0) begin
            errors++; $display("FAIL fetch_misaligned gnt=%b err=%b we=%b want 1 1 0", p_i_gnt, p_i_err, p_m_we);
        end
        @(posedge clk); #1;
        i_addr = 32'h10;
        #1;
        checks++;
        if (p_i_rvalid !== 1'b0 || p_i_gnt !== 1'b1 || p_i_err !== 1'b0 || p_m_a !== 32'h10) begin
            errors++; $display("FAIL fetch_after_err rvalid=%b gnt=%b err=%b m_a=%h", p_i_rvalid, p_i_gnt, p_i_err, p_m_a);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        #1;
        checks++;
        if (p_i_rvalid !== 1'b1 || p_i_rdata !== mm[4] || p_d_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_data rvalid=%b rdata=%h want 1 %h", p_i_rvalid, p_i_rdata, mm[4]);
        end
    endtask

    task automatic test_reset_read();
        @(posedge clk); #1;
        reset = 1'b1; i_req = 1'b1; i_addr = 32'h10;
        #1;
        checks++;
        if (p_i_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_same_grant got=%b want=1", p_i_gnt);
        end
        @(posedge clk); #1;
        reset = 1'b0; i_req = 1'b1;
        #1;
        checks++;
        if (p_i_rvalid !== 1'b0 || p_i_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_same_rvalid got=%b %h want 0", p_i_rvalid, p_i_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b1; i_req = 1'b0;
        #1;
        checks++;
        if (p_i_rvalid !== 1'b0 || p_i_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_next_rvalid got=%b %h want 0", p_i_rvalid, p_i_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (p_i_rvalid !== 1'b0 || p_d_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_after_rvalid got i=%b d=%b want 0", p_i_rvalid, p_d_rvalid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int w = 0; w < 64; w++) begin
            pmem[w] = 32'h0;
            mm[w]   = 32'h0;
        end
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_store();
        test_priority();
        test_round_robin();
        test_fetch();
        test_reset_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
